// File: rtl/mem_burst_pkg.sv
// Shared state type and default sizing for the burst master slice.
package mem_burst_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/mem_burst_master_if.sv
// Command, write-stream, read-stream, memory-port and status bundle of mem_burst_master.
interface mem_burst_master_if
  import mem_burst_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
);

  logic                     cmd_valid_i;
  logic                     cmd_ready_o;
  logic                     cmd_wr_i;
  logic [ADDRESS_WIDTH-1:0] cmd_addr_i;
  logic [ADDRESS_WIDTH:0]   cmd_len_i;
  logic                     wr_valid_i;
  logic                     wr_ready_o;
  logic [WIDTH-1:0]         wr_data_i;
  logic                     rd_valid_o;
  logic                     rd_ready_i;
  logic [WIDTH-1:0]         rd_data_o;
  logic                     rd_last_o;
  logic                     mem_valid_o;
  logic                     mem_wr_rd_en_o;
  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]         mem_wdata_o;
  logic                     mem_ready_i;
  logic [WIDTH-1:0]         mem_rdata_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
    input  wr_valid_i, wr_data_i, rd_ready_i, mem_ready_i, mem_rdata_i,
    output cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, rd_last_o,
    output mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o,
    output busy_o, done_o, err_o
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
    output wr_valid_i, wr_data_i, rd_ready_i, mem_ready_i, mem_rdata_i,
    input  cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, rd_last_o,
    input  mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o,
    input  busy_o, done_o, err_o
  );

endinterface

// File: rtl/mem_burst_rd_buf.sv
// One-entry valid/ready holding register for the read stream (data + last flag).
module mem_burst_rd_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  // Load wins over pop so a same-cycle pop and refill leaves no bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (pop) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// Burst command to single-beat memory transfers. Optional MEM_BURST_BOUND_CHK_EN rejects
// bursts running past DEPTH (err_o + done_o, no traffic); otherwise addresses wrap.
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_burst_master_if.master bus
);

  localparam int unsigned     AW       = ADDRESS_WIDTH;
  localparam logic [AW-1:0]   ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [AW:0]     REM_ONE  = {{AW{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d, addr_inc;
  logic [AW:0]      rem_q, rem_d;
  logic             mem_req, mem_valid, beat;
  logic             buf_load, buf_valid, buf_last;
  logic [WIDTH-1:0] buf_data;
`ifdef MEM_BURST_BOUND_CHK_EN
  localparam logic [AW+1:0] DEPTH_EXT = (AW+2)'(DEPTH);
  logic             err_q, err_d;
  logic [AW+1:0]    cmd_end;
  assign cmd_end = {2'b00, bus.cmd_addr_i} + {1'b0, bus.cmd_len_i};
`endif

  assign addr_inc = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;

  always_comb begin
    mem_req = 1'b0;
    unique case (state_q)
      WRITE:   mem_req = bus.wr_valid_i;
      READ:    mem_req = (rem_q != '0) && (!buf_valid || bus.rd_ready_i);
      default: mem_req = 1'b0;
    endcase
  end

  // Request is masked during reset so the in-flight beat never completes.
  assign mem_valid = mem_req && !rst_i;
  assign beat      = mem_valid && bus.mem_ready_i;

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    rem_d              = rem_q;
    buf_load           = 1'b0;
    bus.cmd_ready_o    = 1'b0;
    bus.wr_ready_o     = 1'b0;
    bus.mem_wr_rd_en_o = 1'b0;
    bus.mem_wdata_o    = '0;
    bus.busy_o         = 1'b1;
    bus.done_o         = 1'b0;
`ifdef MEM_BURST_BOUND_CHK_EN
    err_d              = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready_o = 1'b1;
        bus.busy_o      = 1'b0;
        if (bus.cmd_valid_i) begin
          addr_d = bus.cmd_addr_i;
          rem_d  = bus.cmd_len_i;
          if (bus.cmd_len_i == '0) begin
            state_d = DONE;
`ifdef MEM_BURST_BOUND_CHK_EN
          end else if (cmd_end > DEPTH_EXT) begin
            state_d = DONE;
            err_d   = 1'b1;
`endif
          end else begin
            state_d = bus.cmd_wr_i ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        bus.mem_wr_rd_en_o = 1'b1;
        bus.mem_wdata_o    = bus.wr_data_i;
        bus.wr_ready_o     = bus.mem_ready_i && !rst_i;
        if (beat) begin
          addr_d = addr_inc;
          rem_d  = rem_q - 1'b1;
          if (rem_q == REM_ONE) state_d = DONE;
        end
      end
      READ: begin
        buf_load = beat;
        if (beat) begin
          addr_d = addr_inc;
          rem_d  = rem_q - 1'b1;
        end
        if (buf_valid && bus.rd_ready_i && buf_last) state_d = DONE;
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
`ifdef MEM_BURST_BOUND_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
`ifdef MEM_BURST_BOUND_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  mem_burst_rd_buf #(.WIDTH(WIDTH)) u_rd_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (buf_load),
    .load_data (bus.mem_rdata_i),
    .load_last (rem_q == REM_ONE),
    .pop       (bus.rd_ready_i),
    .valid     (buf_valid),
    .data      (buf_data),
    .last      (buf_last)
  );

  assign bus.mem_valid_o = mem_valid;
  assign bus.mem_addr_o  = addr_q;
  assign bus.rd_valid_o  = buf_valid;
  assign bus.rd_data_o   = buf_data;
  assign bus.rd_last_o   = buf_last;
`ifdef MEM_BURST_BOUND_CHK_EN
  assign bus.err_o       = err_q;
`else
  assign bus.err_o       = 1'b0;
`endif

endmodule
